alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 93 +++++++++
 tb/tb_alu_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one clocked 1-bit ALU between two requesters.
// Each accepted request runs ISSUE -> WAIT -> DONE and then returns to IDLE.
module alu_arbiter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic             a0,
  input  logic             a1,
  input  logic             b0,
  input  logic             b1,
  input  logic [1:0]       sel0,
  input  logic [1:0]       sel1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic             res0,
  output logic             res1,
  output logic             alu_a,
  output logic             alu_b,
  output logic [1:0]       alu_sel,
  input  logic             alu_out,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t state, state_nxt;
  logic   owner;
  logic   last_gnt;
  logic   any_req;
  logic   win;

  assign any_req = req0 | req1;
  // Requester 0 wins if it asks alone, or if both ask and requester 1 was granted last.
  assign win = (req0 && (!req1 || last_gnt)) ? 1'b0 : 1'b1;

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    gnt0  = (state == ISSUE) && !owner;
    gnt1  = (state == ISSUE) &&  owner;
    done0 = (state == DONE)  && !owner;
    done1 = (state == DONE)  &&  owner;
    busy  = (state != IDLE);
  end

  // Operands are captured only at acceptance, so later input changes are ignored.
  always_ff @(posedge clk) begin
    if (!rst) begin
      owner    <= 1'b0;
      last_gnt <= 1'b1;
      alu_a    <= 1'b0;
      alu_b    <= 1'b0;
      alu_sel  <= 2'b00;
      res0     <= 1'b0;
      res1     <= 1'b0;
      op_count <= '0;
    end else begin
      if (state == IDLE && any_req) begin
        owner    <= win;
        last_gnt <= win;
        alu_a    <= win ? a1   : a0;
        alu_b    <= win ? b1   : b0;
        alu_sel  <= win ? sel1 : sel0;
      end
      if (state == WAIT) begin
        if (owner) res1 <= alu_out;
        else       res0 <= alu_out;
        op_count <= op_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a timestamp-based model.
module tb_alu_arbiter;

  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0, req1, a0, a1, b0, b1;
  logic [1:0]       sel0, sel1;
  logic             gnt0, gnt1, done0, done1, res0, res1;
  logic             alu_a, alu_b;
  logic [1:0]       alu_sel;
  logic             alu_out = 1'b0;
  logic             busy;
  logic [CNT_W-1:0] op_count;

  int total = 0;
  int bad   = 0;
  bit checking = 0;

  alu_arbiter #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .a0(a0), .a1(a1), .b0(b0), .b1(b1),
    .sel0(sel0), .sel1(sel1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .res0(res0), .res1(res1),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
    .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  function automatic logic alu_f(input logic a, input logic b, input logic [1:0] s);
    case (s)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~(a ^ b);
    endcase
  endfunction

  always @(posedge clk) alu_out <= alu_f(alu_a, alu_b, alu_sel);

  // Model: an accepted operation is remembered by the edge number that accepted it;
  // every output follows from how many edges have passed since then.
  int         edge_no = 0;
  int         m_start = 0;
  bit         m_busy  = 0;
  bit         m_win   = 0;
  bit         m_last  = 1;
  logic       m_a = 0, m_b = 0;
  logic [1:0] m_sel = 0;
  logic       m_res [2] = '{1'b0, 1'b0};
  logic [CNT_W-1:0] m_cnt = '0;

  always @(posedge clk) begin
    edge_no++;
    if (!rst) begin
      m_busy = 0; m_last = 1; m_a = 0; m_b = 0; m_sel = 0;
      m_res[0] = 0; m_res[1] = 0; m_cnt = '0;
    end else if (!m_busy) begin
      if (req0 || req1) begin
        if (req0 && req1) m_win = ~m_last;
        else              m_win = req1;
        m_a   = m_win ? a1 : a0;
        m_b   = m_win ? b1 : b0;
        m_sel = m_win ? sel1 : sel0;
        m_last  = m_win;
        m_busy  = 1;
        m_start = edge_no;
      end
    end else begin
      if (edge_no - m_start == 2) begin
        m_res[m_win] = alu_f(m_a, m_b, m_sel);
        m_cnt = m_cnt + 1'b1;
      end
      if (edge_no - m_start == 3) m_busy = 0;
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d (time %0t)", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      int ph;
      ph = edge_no - m_start;
      checkOutput("gnt0",     gnt0,     int'(m_busy && ph == 0 && !m_win));
      checkOutput("gnt1",     gnt1,     int'(m_busy && ph == 0 &&  m_win));
      checkOutput("done0",    done0,    int'(m_busy && ph == 2 && !m_win));
      checkOutput("done1",    done1,    int'(m_busy && ph == 2 &&  m_win));
      checkOutput("busy",     busy,     int'(m_busy));
      checkOutput("res0",     res0,     m_res[0]);
      checkOutput("res1",     res1,     m_res[1]);
      checkOutput("alu_a",    alu_a,    m_a);
      checkOutput("alu_b",    alu_b,    m_b);
      checkOutput("alu_sel",  alu_sel,  m_sel);
      checkOutput("op_count", op_count, m_cnt);
      checkOutput("gnt_excl",  int'(gnt0 && gnt1),   0);
      checkOutput("done_excl", int'(done0 && done1), 0);
    end
  end

  task automatic applyStimulus(input logic r0, input logic ia0, input logic ib0, input logic [1:0] s0,
                               input logic r1, input logic ia1, input logic ib1, input logic [1:0] s1);
    req0 = r0; a0 = ia0; b0 = ib0; sel0 = s0;
    req1 = r1; a1 = ia1; b1 = ib1; sel1 = s1;
  endtask

  task automatic doReset();
    rst = 1'b0;
    applyStimulus(0, 0, 0, 2'b00, 0, 0, 0, 2'b00);
    @(negedge clk);
    rst = 1'b1;
  endtask

  int doneCyc [5] = '{3, 7, 11, 15, 19};
  int cntExp  [5] = '{1, 2, 3, 0, 1};

  initial begin
    rst = 1'b0;
    applyStimulus(0, 0, 0, 2'b00, 0, 0, 0, 2'b00);
    repeat (2) @(negedge clk);
    checking = 1;
    checkOutput("rst_busy",     busy,     0);
    checkOutput("rst_op_count", op_count, 0);
    checkOutput("rst_alu_sel",  alu_sel,  0);
    checkOutput("rst_res0",     res0,     0);
    rst = 1'b1;

    // Single request, accepted on the first edge after reset releases.
    applyStimulus(1, 1, 0, 2'b01, 0, 0, 0, 2'b00);
    @(negedge clk);
    checkOutput("single_gnt0",    gnt0,    1);
    checkOutput("single_alu_a",   alu_a,   1);
    checkOutput("single_alu_b",   alu_b,   0);
    checkOutput("single_alu_sel", alu_sel, 1);
    req0 = 0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("single_done0", done0,    1);
    checkOutput("single_res0",  res0,     1);
    checkOutput("single_count", op_count, 1);
    @(negedge clk);
    checkOutput("single_idle", busy, 0);

    // Both held: grants alternate every four cycles; counter wraps at 4.
    doReset();
    applyStimulus(1, 1, 1, 2'b10, 1, 1, 0, 2'b10);
    for (int k = 1; k <= 19; k++) begin
      @(negedge clk);
      if (k % 4 == 1) begin
        checkOutput("rr_gnt0", gnt0, int'(k % 8 == 1));
        checkOutput("rr_gnt1", gnt1, int'(k % 8 == 5));
      end
      for (int j = 0; j < 5; j++) begin
        if (k == doneCyc[j]) begin
          checkOutput("rr_done0", done0,    int'(j % 2 == 0));
          checkOutput("rr_count", op_count, cntExp[j]);
        end
      end
    end
    checkOutput("rr_res0", res0, 0);
    checkOutput("rr_res1", res1, 1);

    // Operand toggle during WAIT must not disturb the latched operation.
    doReset();
    applyStimulus(1, 1, 1, 2'b00, 0, 0, 0, 2'b00);
    @(negedge clk);
    req0 = 0;
    @(negedge clk);
    a0 = 0;
    @(negedge clk);
    checkOutput("toggle_res0",  res0,  1);
    checkOutput("toggle_alu_a", alu_a, 1);

    // Reset during WAIT aborts; a fresh request then completes on time.
    doReset();
    applyStimulus(1, 1, 1, 2'b01, 0, 0, 0, 2'b00);
    @(negedge clk);
    req0 = 0;
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    checkOutput("abort_busy",  busy,     0);
    checkOutput("abort_done0", done0,    0);
    checkOutput("abort_res0",  res0,     0);
    checkOutput("abort_count", op_count, 0);
    rst = 1;
    applyStimulus(1, 0, 1, 2'b10, 0, 0, 0, 2'b00);
    @(negedge clk);
    checkOutput("after_gnt0", gnt0, 1);
    req0 = 0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("after_done0", done0,    1);
    checkOutput("after_res0",  res0,     1);
    checkOutput("after_count", op_count, 1);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 79) != 0);
      applyStimulus(logic'($urandom_range(0, 2) != 0), logic'($urandom_range(0, 1)),
                    logic'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    logic'($urandom_range(0, 2) != 0), logic'($urandom_range(0, 1)),
                    logic'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
    end
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
